// File: rtl/regbank_pkg.sv
// regbank_pkg
// Shared definitions for the register-bank sequencer:
//   - OP_* : 3-bit command opcodes
//   - REG_*: register addresses (10 and 11 both select the accumulator)
//   - state_t : sequencer FSM states
package regbank_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MOV = 3'b101;
  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_RD  = 3'b111;

  localparam logic [1:0] REG_A   = 2'b00;
  localparam logic [1:0] REG_B   = 2'b01;
  localparam logic [1:0] REG_ACC = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_CAPT  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_WRITE = 3'd4,
    ST_RESP  = 3'd5
  } state_t;

endpackage

// File: rtl/regbank_alu.sv
// regbank_alu
// Combinational datapath for the sequencer.
// Ports:
//   op     in  3       opcode (OP_*)
//   op1    in  DATA_W  first operand (captured src1 value)
//   op2    in  DATA_W  second operand (captured src2 value)
//   imm    in  DATA_W  immediate for LDI
//   result out DATA_W  operation result, modulo 2^DATA_W
//   carry  out 1       ADD carry-out / SUB borrow, 0 for all other ops
module regbank_alu
  import regbank_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  // One extra bit on the arithmetic paths: its MSB is the carry for ADD
  // and the borrow for SUB (set exactly when op1 < op2 unsigned).
  logic [DATA_W:0]   sum_ext;
  logic [DATA_W:0]   diff_ext;
  logic [DATA_W-1:0] and_v;
  logic [DATA_W-1:0] or_v;
  logic [DATA_W-1:0] xor_v;

  assign sum_ext  = {1'b0, op1} + {1'b0, op2};
  assign diff_ext = {1'b0, op1} - {1'b0, op2};

  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bitwise
      assign and_v[gi] = op1[gi] & op2[gi];
      assign or_v[gi]  = op1[gi] | op2[gi];
      assign xor_v[gi] = op1[gi] ^ op2[gi];
    end
  endgenerate

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum_ext[DATA_W-1:0];
        carry  = sum_ext[DATA_W];
      end
      OP_SUB: begin
        result = diff_ext[DATA_W-1:0];
        carry  = diff_ext[DATA_W];
      end
      OP_AND:  result = and_v;
      OP_OR:   result = or_v;
      OP_XOR:  result = xor_v;
      OP_MOV:  result = op1;
      OP_LDI:  result = imm;
      OP_RD:   result = op1;
      default: result = op1;
    endcase
  end

endmodule

// File: rtl/regbank_sequencer.sv
// regbank_sequencer
// Initiator for the 4-entry register bank. Accepts one command at a time,
// reads its sources from the bank, computes, writes the result back and
// returns it on a response handshake.
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (ready only in IDLE)
//   cmd_op/src1/src2/dst/imm command fields, latched on accept
//   bank_opwrite             1 = write cycle, 0 = read
//   bank_reg_write/bank_data write address and value
//   bank_src_1/bank_src_2    read addresses
//   bank_rdata_1/2           read data returned by the bank
//   resp_valid/resp_ready    response handshake
//   resp_data/aux/zero/carry result, src2 value, zero flag, carry/borrow
// Schedule: READ -> CAPT -> EXEC -> WRITE -> RESP. LDI enters at EXEC,
// RD skips WRITE. Every bank_* and resp_* output is a flop.
module regbank_sequencer
  import regbank_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_src1,
  input  logic [ADDR_W-1:0] cmd_src2,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              bank_opwrite,
  output logic [ADDR_W-1:0] bank_reg_write,
  output logic [ADDR_W-1:0] bank_src_1,
  output logic [ADDR_W-1:0] bank_src_2,
  output logic [DATA_W-1:0] bank_data,
  input  logic [DATA_W-1:0] bank_rdata_1,
  input  logic [DATA_W-1:0] bank_rdata_2,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [DATA_W-1:0] resp_aux,
  output logic              resp_zero,
  output logic              resp_carry
);

  state_t state_reg;
  state_t state_next;

  logic [2:0]        op_reg;
  logic [ADDR_W-1:0] dst_reg;
  logic [DATA_W-1:0] imm_reg;
  logic [DATA_W-1:0] op1_reg;
  logic [DATA_W-1:0] op2_reg;

  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;

  regbank_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op     (op_reg),
    .op1    (op1_reg),
    .op2    (op2_reg),
    .imm    (imm_reg),
    .result (alu_result),
    .carry  (alu_carry)
  );

  // Reset forces IDLE, so ready is high even while RST is held.
  assign cmd_ready = (state_reg == ST_IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (cmd_valid) state_next = (cmd_op == OP_LDI) ? ST_EXEC : ST_READ;
      ST_READ:  state_next = ST_CAPT;
      ST_CAPT:  state_next = ST_EXEC;
      ST_EXEC:  state_next = (op_reg == OP_RD) ? ST_RESP : ST_WRITE;
      ST_WRITE: state_next = ST_RESP;
      ST_RESP:  if (resp_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Outputs are loaded on the edge that enters the state they belong to,
  // so each is stable for the whole cycle of that state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op_reg         <= '0;
      dst_reg        <= '0;
      imm_reg        <= '0;
      op1_reg        <= '0;
      op2_reg        <= '0;
      bank_opwrite   <= 1'b0;
      bank_reg_write <= '0;
      bank_src_1     <= '0;
      bank_src_2     <= '0;
      bank_data      <= '0;
      resp_valid     <= 1'b0;
      resp_data      <= '0;
      resp_aux       <= '0;
      resp_zero      <= 1'b0;
      resp_carry     <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_reg  <= cmd_op;
            dst_reg <= cmd_dst;
            imm_reg <= cmd_imm;
            // LDI never reads, so leave the bank read addresses untouched.
            if (cmd_op != OP_LDI) begin
              bank_src_1 <= cmd_src1;
              bank_src_2 <= cmd_src2;
            end
          end
        end
        ST_CAPT: begin
          op1_reg <= bank_rdata_1;
          op2_reg <= bank_rdata_2;
        end
        ST_EXEC: begin
          resp_data  <= alu_result;
          resp_aux   <= (op_reg == OP_LDI) ? '0 : op2_reg;
          resp_zero  <= (alu_result == '0);
          resp_carry <= alu_carry;
          if (op_reg == OP_RD) begin
            resp_valid <= 1'b1;
          end else begin
            bank_opwrite   <= 1'b1;
            bank_reg_write <= dst_reg;
            bank_data      <= alu_result;
          end
        end
        ST_WRITE: begin
          bank_opwrite <= 1'b0;
          resp_valid   <= 1'b1;
        end
        ST_RESP: begin
          if (resp_ready) resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_sequencer.sv
module tb_regbank_sequencer;

  localparam int DW = 32;
  localparam int AW = 2;

  localparam logic [2:0] T_ADD = 3'd0;
  localparam logic [2:0] T_SUB = 3'd1;
  localparam logic [2:0] T_AND = 3'd2;
  localparam logic [2:0] T_OR  = 3'd3;
  localparam logic [2:0] T_XOR = 3'd4;
  localparam logic [2:0] T_MOV = 3'd5;
  localparam logic [2:0] T_LDI = 3'd6;
  localparam logic [2:0] T_RD  = 3'd7;

  logic          CLK = 1'b0;
  logic          RST;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_src1, cmd_src2, cmd_dst;
  logic [DW-1:0] cmd_imm;
  logic          bank_opwrite;
  logic [AW-1:0] bank_reg_write, bank_src_1, bank_src_2;
  logic [DW-1:0] bank_data;
  logic [DW-1:0] bank_rdata_1, bank_rdata_2;
  logic          resp_valid, resp_ready;
  logic [DW-1:0] resp_data, resp_aux;
  logic          resp_zero, resp_carry;

  int checks   = 0;
  int failures = 0;
  int last_wait = 0;

  // Reference register file: index 0=a, 1=b, 2=acc.
  logic [DW-1:0] ref_regs [0:2];
  // Behavioural register bank the DUT talks to.
  logic [DW-1:0] bank_regs [0:2];

  always #5 CLK = ~CLK;

  regbank_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_src1       (cmd_src1),
    .cmd_src2       (cmd_src2),
    .cmd_dst        (cmd_dst),
    .cmd_imm        (cmd_imm),
    .bank_opwrite   (bank_opwrite),
    .bank_reg_write (bank_reg_write),
    .bank_src_1     (bank_src_1),
    .bank_src_2     (bank_src_2),
    .bank_data      (bank_data),
    .bank_rdata_1   (bank_rdata_1),
    .bank_rdata_2   (bank_rdata_2),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_data      (resp_data),
    .resp_aux       (resp_aux),
    .resp_zero      (resp_zero),
    .resp_carry     (resp_carry)
  );

  function automatic int ridx(input logic [1:0] a);
    return a[1] ? 2 : int'(a[0]);
  endfunction

  // Bank: writes captured on negedge, read data updated on posedge while reading.
  always @(negedge CLK) if (bank_opwrite) bank_regs[ridx(bank_reg_write)] <= bank_data;
  always @(posedge CLK) begin
    if (!bank_opwrite) begin
      bank_rdata_1 <= bank_regs[ridx(bank_src_1)];
      bank_rdata_2 <= bank_regs[ridx(bank_src_2)];
    end
  end

  // Issue one command, follow it to its response, check against the model.
  task automatic run_cmd(input string name, input logic [2:0] op, input logic [1:0] s1,
                         input logic [1:0] s2, input logic [1:0] d, input logic [DW-1:0] imm,
                         input int hold, input bit keep_valid);
    logic [DW-1:0] a, b, ed, ea, wd;
    logic          ec, ez;
    logic [1:0]    wa;
    longint        wide;
    bit            ew;
    int            el, lat, wcnt, wk, cnt;
    a  = ref_regs[ridx(s1)];
    b  = ref_regs[ridx(s2)];
    ec = 1'b0;
    ew = (op != T_RD);
    el = (op == T_LDI) ? 3 : (op == T_RD) ? 4 : 5;
    ea = (op == T_LDI) ? '0 : b;
    case (op)
      T_ADD: begin
        wide = longint'(a) + longint'(b);
        ed   = wide[DW-1:0];
        ec   = (wide > 64'h0000_0000_FFFF_FFFF);
      end
      T_SUB: begin ed = a - b; ec = (a < b); end
      T_AND: ed = a & b;
      T_OR:  ed = a | b;
      T_XOR: ed = a ^ b;
      T_LDI: ed = imm;
      default: ed = a;  // MOV, RD
    endcase
    ez = (ed == '0);

    cmd_op = op; cmd_src1 = s1; cmd_src2 = s2; cmd_dst = d; cmd_imm = imm;
    cmd_valid = 1'b1;
    cnt = 0;
    while (!cmd_ready && cnt < 50) begin
      @(negedge CLK);
      cnt++;
    end
    last_wait = cnt;
    checks++;
    if (!cmd_ready) begin
      failures++;
      $display("FAIL %s accept_timeout cmd_ready=%0b required=1", name, cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge CLK);  // accept edge
    #1;
    if (!keep_valid) cmd_valid = 1'b0;

    lat = 0; wcnt = 0; wk = 0; wa = '0; wd = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      if (k == 1 && op != T_LDI) begin
        checks++;
        if (bank_src_1 !== s1 || bank_src_2 !== s2 || bank_opwrite !== 1'b0) begin
          failures++;
          $display("FAIL %s read_addr src1=%0d src2=%0d opwrite=%0b required %0d %0d 0",
                   name, bank_src_1, bank_src_2, bank_opwrite, s1, s2);
        end
      end
      if (bank_opwrite) begin
        wcnt++; wk = k; wa = bank_reg_write; wd = bank_data;
      end
      if (resp_valid) begin
        lat = k;
        break;
      end
      resp_ready = 1'($urandom);  // ignored outside RESP
      if (keep_valid) begin
        cmd_op = 3'($urandom); cmd_src1 = 2'($urandom); cmd_src2 = 2'($urandom);
        cmd_dst = 2'($urandom); cmd_imm = $urandom;
      end
    end
    resp_ready = (hold == 0);

    checks++;
    if (lat != el) begin
      failures++;
      $display("FAIL %s latency got=%0d required=%0d", name, lat, el);
      if (lat == 0) return;
    end
    checks++;
    if (wcnt != (ew ? 1 : 0)) begin
      failures++;
      $display("FAIL %s write_count got=%0d required=%0d", name, wcnt, ew ? 1 : 0);
    end
    if (ew && wcnt == 1) begin
      checks++;
      if (wk != lat - 1 || wa !== d || wd !== ed) begin
        failures++;
        $display("FAIL %s bank_write cyc=%0d addr=%0d data=%h required cyc=%0d addr=%0d data=%h",
                 name, wk, wa, wd, lat - 1, d, ed);
      end
    end
    checks++;
    if (resp_data !== ed || resp_aux !== ea) begin
      failures++;
      $display("FAIL %s resp_data got=%h aux=%h required data=%h aux=%h", name, resp_data, resp_aux, ed, ea);
    end
    checks++;
    if (resp_zero !== ez || resp_carry !== ec || cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s flags zero=%0b carry=%0b ready=%0b required %0b %0b 0",
               name, resp_zero, resp_carry, cmd_ready, ez, ec);
    end

    for (int h = 0; h < hold; h++) begin
      @(negedge CLK);
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== ed || resp_aux !== ea || cmd_ready !== 1'b0 ||
          bank_opwrite !== 1'b0) begin
        failures++;
        $display("FAIL %s hold_stable valid=%0b data=%h ready=%0b opwrite=%0b required 1 %h 0 0",
                 name, resp_valid, resp_data, cmd_ready, bank_opwrite, ed);
      end
    end
    resp_ready = 1'b1;
    @(posedge CLK);  // response handshake
    #1;
    resp_ready = 1'b0;
    @(negedge CLK);
    checks++;
    if (resp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s after_handshake valid=%0b ready=%0b required 0 1", name, resp_valid, cmd_ready);
    end
    if (ew) ref_regs[ridx(d)] = ed;
    $display("TXN %s op=%0d s1=%0d s2=%0d d=%0d imm=%h -> data=%h aux=%h z=%0b c=%0b lat=%0d",
             name, op, s1, s2, d, imm, resp_data, resp_aux, resp_zero, resp_carry, lat);
  endtask

  task automatic test_reset();
    RST = 1'b1; cmd_valid = 1'b0; resp_ready = 1'b0;
    cmd_op = '0; cmd_src1 = '0; cmd_src2 = '0; cmd_dst = '0; cmd_imm = '0;
    repeat (3) @(negedge CLK);
    checks++;
    if (cmd_ready !== 1'b1 || bank_opwrite !== 1'b0 || bank_reg_write !== '0 || bank_src_1 !== '0 ||
        bank_src_2 !== '0 || bank_data !== '0 || resp_valid !== 1'b0 || resp_data !== '0 ||
        resp_aux !== '0 || resp_zero !== 1'b0 || resp_carry !== 1'b0) begin
      failures++;
      $display("FAIL reset_state ready=%0b opwrite=%0b resp_valid=%0b resp_data=%h required 1 0 0 0",
               cmd_ready, bank_opwrite, resp_valid, resp_data);
    end
    RST = 1'b0;
    @(negedge CLK);
    $display("TXN reset done");
  endtask

  task automatic test_ldi_rd();
    run_cmd("ldi_a",  T_LDI, 2'd0, 2'd0, 2'd0, 32'd256, 0, 1'b0);
    run_cmd("ldi_b",  T_LDI, 2'd0, 2'd0, 2'd1, 32'd128, 0, 1'b0);
    run_cmd("ldi_acc", T_LDI, 2'd0, 2'd0, 2'd2, 32'h0BAD_F00D, 0, 1'b0);
    run_cmd("rd_ab",  T_RD,  2'd0, 2'd1, 2'd2, 32'h0, 0, 1'b0);
  endtask

  task automatic test_add_wrap();
    run_cmd("ldi_ff", T_LDI, 2'd0, 2'd0, 2'd0, 32'hFFFF_FFFF, 0, 1'b0);
    run_cmd("ldi_1",  T_LDI, 2'd0, 2'd0, 2'd1, 32'd1, 0, 1'b0);
    run_cmd("add_wrap", T_ADD, 2'd0, 2'd1, 2'd2, 32'h0, 0, 1'b0);
    run_cmd("rd_acc0", T_RD, 2'd2, 2'd0, 2'd0, 32'h0, 0, 1'b0);
  endtask

  task automatic test_sub_borrow();
    run_cmd("ldi_5", T_LDI, 2'd0, 2'd0, 2'd1, 32'd5, 0, 1'b0);
    run_cmd("ldi_7", T_LDI, 2'd0, 2'd0, 2'd0, 32'd7, 0, 1'b0);
    run_cmd("sub_borrow", T_SUB, 2'd1, 2'd0, 2'd3, 32'h0, 0, 1'b0);
    run_cmd("rd_acc_fe", T_RD, 2'd2, 2'd1, 2'd0, 32'h0, 0, 1'b0);
  endtask

  task automatic test_resp_hold();
    run_cmd("or_hold", T_OR, 2'd0, 2'd1, 2'd2, 32'h0, 4, 1'b1);
    run_cmd("and_next", T_AND, 2'd2, 2'd1, 2'd0, 32'h0, 0, 1'b0);
    checks++;
    if (last_wait != 0) begin
      failures++;
      $display("FAIL accept_after_handshake wait=%0d required=0", last_wait);
    end
  endtask

  task automatic test_reset_mid_cmd();
    bit saw_write;
    run_cmd("ldi_acc_k", T_LDI, 2'd0, 2'd0, 2'd2, 32'h1234_5678, 0, 1'b0);
    cmd_op = T_ADD; cmd_src1 = 2'd0; cmd_src2 = 2'd1; cmd_dst = 2'd2; cmd_imm = '0;
    cmd_valid = 1'b1;
    @(posedge CLK);  // accepted: DUT was idle
    #1 cmd_valid = 1'b0;
    @(negedge CLK);  // READ
    @(negedge CLK);  // CAPT
    #1 RST = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || bank_opwrite !== 1'b0 || bank_src_1 !== '0 || bank_src_2 !== '0 ||
        bank_data !== '0 || bank_reg_write !== '0 || resp_valid !== 1'b0 || resp_data !== '0 ||
        resp_aux !== '0 || resp_zero !== 1'b0 || resp_carry !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_outputs ready=%0b src2=%0d resp_data=%h required 1 0 0",
               cmd_ready, bank_src_2, resp_data);
    end
    saw_write = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (i == 2) RST = 1'b0;
      if (bank_opwrite || resp_valid) saw_write = 1'b1;
    end
    checks++;
    if (saw_write) begin
      failures++;
      $display("FAIL mid_reset_no_write activity=%0b required=0", saw_write);
    end
    $display("TXN reset during CAPT of ADD");
    run_cmd("rd_acc_kept", T_RD, 2'd2, 2'd1, 2'd0, 32'h0, 0, 1'b0);
    run_cmd("add_after_rst", T_ADD, 2'd0, 2'd1, 2'd2, 32'h0, 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_cmd("ldi_a_r", T_LDI, 2'd0, 2'd0, 2'd0, $urandom, 0, 1'b0);
    run_cmd("ldi_b_r", T_LDI, 2'd0, 2'd0, 2'd1, $urandom, 0, 1'b0);
    run_cmd("xor_ab", T_XOR, 2'd0, 2'd1, 2'd2, 32'h0, 0, 1'b0);
    run_cmd("mov_acc_a", T_MOV, 2'd3, 2'd1, 2'd0, 32'h0, 0, 1'b0);
    run_cmd("rd_a", T_RD, 2'd0, 2'd2, 2'd1, 32'h0, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [DW-1:0] imm;
    for (int i = 0; i < 40; i++) begin
      imm = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      run_cmd("rand", 3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), imm,
              int'($urandom_range(0, 2)), 1'($urandom));
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) ref_regs[i] = '0;
    test_reset();
    test_ldi_rd();
    test_add_wrap();
    test_sub_borrow();
    test_resp_hold();
    test_reset_mid_cmd();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout time=%0t required_finish_before=500000", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regbank_sequencer.md
Name: regbank_sequencer

Overview:
Initiator side of the 4-entry register-bank port: accepts one ALU-style command at a time on a valid/ready handshake and drives the bank's read and write controls in a fixed multi-cycle schedule.
- Sequence: read the source registers, capture the read data, compute, write the result back, return it on a response handshake.
- Sits between the instruction front end and the register bank, and is the only master of the bank's opwrite/reg_write/src_1/src_2/data inputs.

Parameters:
DATA_W, 32, register and data width
ADDR_W, 2, register address width (00=reg_a, 01=reg_b, 10/11=acc)

Ports:
CLK  in  1  clock; all state updates on posedge
RST  in  1  asynchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  sequencer idle, can accept
cmd_op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MOV, 110 LDI, 111 RD
cmd_src1  in  ADDR_W  first source register
cmd_src2  in  ADDR_W  second source register
cmd_dst  in  ADDR_W  destination register
cmd_imm  in  DATA_W  immediate for LDI
bank_opwrite  out  1  to bank opwrite; 1=write, 0=read
bank_reg_write  out  ADDR_W  to bank reg_write
bank_src_1  out  ADDR_W  to bank src_1
bank_src_2  out  ADDR_W  to bank src_2
bank_data  out  DATA_W  to bank data (write value)
bank_rdata_1  in  DATA_W  from bank data_src_1
bank_rdata_2  in  DATA_W  from bank data_src_2
resp_valid  out  1  result available
resp_ready  in  1  consumer accepts result
resp_data  out  DATA_W  result (RD: src1 value)
resp_aux  out  DATA_W  src2 value as read (0 for LDI)
resp_zero  out  1  resp_data == 0
resp_carry  out  1  ADD carry-out / SUB borrow; 0 otherwise

Behaviour:
- Reset (async, immediate): state IDLE; bank_opwrite=0, bank_reg_write=0, bank_src_1=0, bank_src_2=0, bank_data=0; resp_valid=0, resp_data=0, resp_aux=0, resp_zero=0, resp_carry=0. Assertion mid-command abandons it. A write already issued stays in the bank; no write is issued after reset.
- All bank_* and resp_* outputs are registered. cmd_ready = (state==IDLE), so it reads 1 during reset.
- States: IDLE, READ, CAPT, EXEC, WRITE, RESP.
- IDLE: on cmd_valid=1, latch op/src1/src2/dst/imm and go to READ. LDI skips to EXEC.
- READ (1 cycle): bank_opwrite=0, bank_src_1/2 = latched sources. The bank updates data_src at the posedge ending READ.
- CAPT (1 cycle): sample bank_rdata_1/2 into operand registers at the posedge ending CAPT; bank_opwrite stays 0.
- EXEC (1 cycle): compute result.
  - Arithmetic is DATA_W+1 bits internally; carry = bit DATA_W.
  - SUB carry = 1 when op1 < op2 unsigned. Results wrap modulo 2^DATA_W.
  - MOV: result = op1. LDI: result = imm. RD: result = op1, no write.
- WRITE (1 cycle, skipped for RD): bank_opwrite=1, bank_reg_write=dst, bank_data=result, all held stable the whole cycle so the bank's negedge capture sees them. On exit bank_opwrite returns to 0.
- RESP: resp_valid=1, outputs held stable until resp_valid & resp_ready, then IDLE. resp_ready=1 on the first RESP cycle completes in one cycle.
- Latency:
  - ALU/MOV: accept edge T, resp_valid at T+5.
  - RD: T+4.
  - LDI: T+3.
  - Next command can be accepted the cycle after the response handshake.
- Hazards: a command reading the previous dst sees the written value, since the write completes before IDLE. dst=11 and dst=10 both target acc.
- cmd_* inputs outside IDLE are ignored. resp_ready outside RESP is ignored.

Decomposition:
- Shared package regbank_pkg:
  - opcode localparams OP_ADD..OP_RD
  - register address constants REG_A=00, REG_B=01, REG_ACC=10
  - state encoding
- Sub-module regbank_alu: combinational; op, op1, op2, imm -> result, carry. The FSM stays in regbank_sequencer.

Test Plan:
- LDI dst=00 imm=256, then LDI dst=01 imm=128, then RD src1=00 src2=01 -> resp_data=256, resp_aux=128; bank writes seen only in WRITE cycles.
- ADD src1=00(0xFFFFFFFF) src2=01(1) dst=10 -> resp_data=0, resp_zero=1, resp_carry=1; later RD of acc returns 0; resp_valid exactly 5 cycles after accept.
- SUB src1=01(5) src2=00(7) dst=11 -> resp_data=0xFFFFFFFE, carry=1; RD src1=10 returns 0xFFFFFFFE.
- Hold resp_ready=0 for 4 cycles in RESP with cmd_valid=1 -> resp_* stable, cmd_ready=0, no new bank activity; accept occurs the cycle after the handshake.
- Assert RST during CAPT of an ADD -> outputs reset immediately, bank_opwrite never pulses, destination register keeps its old value; a following command runs normally.
- Back-to-back XOR a,b->acc then MOV acc->a -> reg_a equals a^b; bank_opwrite is 0 in all non-WRITE cycles.
